// File: rtl/zbt_sram_pkg.sv
// Shared widths, latencies and state type for the ZBT SSRAM controller.
package zbt_sram_pkg;

    localparam int unsigned SRAM_ADDR_W     = 18;
    localparam int unsigned SRAM_DATA_W     = 32;
    localparam int unsigned SRAM_MASK_W     = 4;
    localparam int unsigned SRAM_RD_LATENCY = 4;
    localparam int unsigned SRAM_WR_DELAY   = 2;

    typedef enum logic [1:0] {
        StInit,
        StRun,
        StSleep,
        StWake
    } sram_state_e;

    // Width of one down-counter shared by the init, wake and idle timers.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 2);
    endfunction

endpackage

// File: rtl/zbt_sram_pipe.sv
// Fixed-depth shift pipeline for request flags and write data; reset flushes every stage.
module zbt_sram_pipe #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 34
) (
    input  logic             sram_clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge sram_clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/zbt_sram_ctrl.sv
// Responder for single-word SRAM requests driving a pipelined ZBT SSRAM.
// Define SRAM_ZZ_EN to add idle ZZ sleep with wake-on-request.
module zbt_sram_ctrl
    import zbt_sram_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = 16,
    parameter int unsigned IDLE_SLEEP  = 256,
    parameter int unsigned WAKE_CYCLES = 8
) (
    input  logic                   sram_clock,
    input  logic                   reset,
    input  logic                   sram_addr_valid,
    output logic                   sram_ready,
    input  logic [SRAM_ADDR_W-1:0] sram_addr,
    input  logic [SRAM_DATA_W-1:0] sram_data_in,
    input  logic [SRAM_MASK_W-1:0] sram_write_mask,
    output logic [SRAM_DATA_W-1:0] sram_data_out,
    output logic                   sram_data_out_valid,
    output logic [SRAM_ADDR_W-1:0] ram_addr,
    output logic                   ram_ce_n,
    output logic                   ram_we_n,
    output logic [SRAM_MASK_W-1:0] ram_bw_n,
    output logic [SRAM_DATA_W-1:0] ram_dq_o,
    output logic                   ram_dq_oe,
    input  logic [SRAM_DATA_W-1:0] ram_dq_i,
    output logic                   ram_zz
);

    localparam int unsigned CntW  = cnt_width(INIT_CYCLES, IDLE_SLEEP, WAKE_CYCLES);
    localparam int unsigned PipeW = SRAM_DATA_W + 2;

    sram_state_e     state_q;
    logic [CntW-1:0] cnt_q;
    logic            ready_q;
    logic            accept;
    logic            is_write;
    logic            rd_flag;
    logic [PipeW-1:0] pipe_out;

    assign accept   = sram_addr_valid && ready_q;
    assign is_write = |sram_write_mask;

`ifdef SRAM_ZZ_EN
    logic                       zz_q;
    logic [CntW-1:0]            idle_q;
    logic [SRAM_RD_LATENCY-1:0] inflight_q;

    // Tracks accepts still travelling towards the read return strobe.
    always_ff @(posedge sram_clock) begin
        if (reset) inflight_q <= '0;
        else       inflight_q <= {inflight_q[SRAM_RD_LATENCY-2:0], accept};
    end

    assign ram_zz = zz_q;
`else
    assign ram_zz = 1'b0;
`endif

    always_ff @(posedge sram_clock) begin
        if (reset) begin
            state_q <= StInit;
            cnt_q   <= CntW'(INIT_CYCLES);
            ready_q <= 1'b0;
`ifdef SRAM_ZZ_EN
            zz_q    <= 1'b0;
            idle_q  <= '0;
`endif
        end else begin
            case (state_q)
                StInit: begin
                    if (cnt_q <= CntW'(1)) begin
                        state_q <= StRun;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
`ifdef SRAM_ZZ_EN
                StRun: begin
                    if (accept || inflight_q != '0) begin
                        idle_q <= '0;
                    end else if (idle_q >= CntW'(IDLE_SLEEP - 1)) begin
                        state_q <= StSleep;
                        ready_q <= 1'b0;
                        zz_q    <= 1'b1;
                        idle_q  <= '0;
                    end else begin
                        idle_q <= idle_q + CntW'(1);
                    end
                end
                StSleep: begin
                    if (sram_addr_valid) begin
                        state_q <= StWake;
                        zz_q    <= 1'b0;
                        cnt_q   <= CntW'(WAKE_CYCLES);
                    end
                end
                StWake: begin
                    if (cnt_q <= CntW'(1)) begin
                        state_q <= StRun;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
`else
                StRun: begin
                end
`endif
                default: begin
                    state_q <= StInit;
                    cnt_q   <= CntW'(INIT_CYCLES);
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign sram_ready = ready_q;

    // Address/control pins: registered at the accept edge, idle otherwise.
    always_ff @(posedge sram_clock) begin
        if (reset) begin
            ram_addr <= '0;
            ram_ce_n <= 1'b1;
            ram_we_n <= 1'b1;
            ram_bw_n <= '1;
        end else begin
            ram_ce_n <= ~accept;
            ram_we_n <= ~(accept && is_write);
            ram_bw_n <= accept ? ~sram_write_mask : '1;
            if (accept) ram_addr <= sram_addr;
        end
    end

    // First stage lines up with the address pins; last stage is the SSRAM data cycle.
    zbt_sram_pipe #(
        .DEPTH(SRAM_WR_DELAY + 1),
        .WIDTH(PipeW)
    ) u_pipe (
        .sram_clock(sram_clock),
        .reset     (reset),
        .din       ({accept && !is_write, accept && is_write, sram_data_in}),
        .dout      (pipe_out)
    );

    assign rd_flag   = pipe_out[SRAM_DATA_W+1];
    assign ram_dq_oe = pipe_out[SRAM_DATA_W];
    assign ram_dq_o  = pipe_out[SRAM_DATA_W-1:0];

    always_ff @(posedge sram_clock) begin
        if (reset) begin
            sram_data_out       <= '0;
            sram_data_out_valid <= 1'b0;
        end else begin
            sram_data_out_valid <= rd_flag;
            if (rd_flag) sram_data_out <= ram_dq_i;
        end
    end

endmodule

// File: tb/tb_zbt_sram_ctrl.sv
// Directed bench for zbt_sram_ctrl with a behavioural pipelined ZBT SSRAM model.
module tb_zbt_sram_ctrl;

    logic        sram_clock = 1'b0;
    logic        reset;
    logic        sram_addr_valid;
    logic        sram_ready;
    logic [17:0] sram_addr;
    logic [31:0] sram_data_in;
    logic [3:0]  sram_write_mask;
    logic [31:0] sram_data_out;
    logic        sram_data_out_valid;
    logic [17:0] ram_addr;
    logic        ram_ce_n;
    logic        ram_we_n;
    logic [3:0]  ram_bw_n;
    logic [31:0] ram_dq_o;
    logic        ram_dq_oe;
    logic [31:0] ram_dq_i = 32'h0;
    logic        ram_zz;

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    zbt_sram_ctrl #(
        .INIT_CYCLES(16),
        .IDLE_SLEEP (4),
        .WAKE_CYCLES(3)
    ) dut (
        .sram_clock         (sram_clock),
        .reset              (reset),
        .sram_addr_valid    (sram_addr_valid),
        .sram_ready         (sram_ready),
        .sram_addr          (sram_addr),
        .sram_data_in       (sram_data_in),
        .sram_write_mask    (sram_write_mask),
        .sram_data_out      (sram_data_out),
        .sram_data_out_valid(sram_data_out_valid),
        .ram_addr           (ram_addr),
        .ram_ce_n           (ram_ce_n),
        .ram_we_n           (ram_we_n),
        .ram_bw_n           (ram_bw_n),
        .ram_dq_o           (ram_dq_o),
        .ram_dq_oe          (ram_dq_oe),
        .ram_dq_i           (ram_dq_i),
        .ram_zz             (ram_zz)
    );

    always #5 sram_clock = ~sram_clock;

    // SSRAM model: address sampled at edge k, read data driven after k+1, write data taken at k+2.
    logic [31:0] mem [logic [17:0]];
    logic        s0_v = 1'b0, s0_we = 1'b0, s1_v = 1'b0, s1_we = 1'b0;
    logic [3:0]  s0_bw = 4'hF, s1_bw = 4'hF;
    logic [17:0] s0_a = '0, s1_a = '0;
    logic        m_drive = 1'b0;

    always @(posedge sram_clock) begin : zbt_model
        logic [31:0] w;
        if (s1_v && s1_we && ram_dq_oe) begin
            w = mem.exists(s1_a) ? mem[s1_a] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (!s1_bw[b]) w[8*b +: 8] = ram_dq_o[8*b +: 8];
            mem[s1_a] = w;
        end
        if (s0_v && !s0_we) begin
            ram_dq_i <= mem.exists(s0_a) ? mem[s0_a] : 32'h0;
            m_drive  <= 1'b1;
        end else begin
            ram_dq_i <= 32'h0;
            m_drive  <= 1'b0;
        end
        s1_v = s0_v; s1_we = s0_we; s1_bw = s0_bw; s1_a = s0_a;
        s0_v = !ram_ce_n; s0_we = !ram_we_n; s0_bw = ram_bw_n; s0_a = ram_addr;
    end

    always @(negedge sram_clock) if (m_drive && ram_dq_oe) overlap++;

    task automatic tick;
        @(negedge sram_clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; sram_addr_valid = 1'b1; sram_addr = '0;
        sram_data_in = '0; sram_write_mask = '0;
        mem[18'h00001] = 32'h1111_0001;
        mem[18'h00003] = 32'h3333_0003;
        mem[18'h3FFFF] = 32'hA5A5_3FFF;
        repeat (3) @(posedge sram_clock);
        @(negedge sram_clock);
        reset = 1'b0;

        // Reset values, then 16 INIT cycles with addr_valid held high
        chk("rst_data_out", sram_data_out, 32'h0);
        chk("rst_valid", sram_data_out_valid, 1'b0);
        chk("rst_we_n", ram_we_n, 1'b1);
        chk("rst_bw_n", ram_bw_n, 4'hF);
        chk("rst_oe", ram_dq_oe, 1'b0);
        chk("rst_addr", ram_addr, 18'h0);
        chk("rst_zz", ram_zz, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk("init_ready", sram_ready, 1'b0);
            chk("init_ce_n", ram_ce_n, 1'b1);
            tick();
        end
        chk("init_done_ready", sram_ready, 1'b1);
        sram_addr_valid = 1'b0;

        // Full write then read-back of 0x00012
        tick();
        sram_addr = 18'h00012; sram_data_in = 32'hDEADBEEF; sram_write_mask = 4'hF;
        sram_addr_valid = 1'b1;
        tick();
        sram_addr_valid = 1'b0;
        chk("wr_ce_n", ram_ce_n, 1'b0);
        chk("wr_we_n", ram_we_n, 1'b0);
        chk("wr_bw_n", ram_bw_n, 4'h0);
        chk("wr_addr", ram_addr, 18'h00012);
        tick();
        chk("wr_oe_early", ram_dq_oe, 1'b0);
        tick();
        chk("wr_oe", ram_dq_oe, 1'b1);
        chk("wr_dq", ram_dq_o, 32'hDEADBEEF);
        tick();
        chk("wr_oe_late", ram_dq_oe, 1'b0);
        sram_write_mask = 4'h0; sram_addr_valid = 1'b1;
        tick();
        sram_addr_valid = 1'b0;
        chk("rd_ce_n", ram_ce_n, 1'b0);
        chk("rd_we_n", ram_we_n, 1'b1);
        chk("rd_bw_n", ram_bw_n, 4'hF);
        tick(); tick();
        chk("rd_valid_early", sram_data_out_valid, 1'b0);
        tick();
        chk("rd_valid", sram_data_out_valid, 1'b1);
        chk("rd_data", sram_data_out, 32'hDEADBEEF);
        tick();
        chk("rd_valid_once", sram_data_out_valid, 1'b0);
        chk("rd_hold", sram_data_out, 32'hDEADBEEF);

        // Partial byte write over all-ones, read back back-to-back
        sram_addr = 18'h00020; sram_data_in = 32'hFFFFFFFF; sram_write_mask = 4'hF;
        sram_addr_valid = 1'b1;
        tick();
        sram_data_in = 32'h11223344; sram_write_mask = 4'b0101;
        tick();
        chk("pw_bw_n", ram_bw_n, 4'b1010);
        sram_write_mask = 4'h0;
        tick();
        sram_addr_valid = 1'b0;
        repeat (3) tick();
        chk("pw_valid", sram_data_out_valid, 1'b1);
        chk("pw_data", sram_data_out, 32'hFF22FF44);

        // Alternating W0 R1 W2 R3 on consecutive cycles
        tick();
        chk("alt_ready0", sram_ready, 1'b1);
        sram_addr = 18'd0; sram_data_in = 32'hC0FFEE00; sram_write_mask = 4'hF;
        sram_addr_valid = 1'b1;
        tick();
        chk("alt_ready1", sram_ready, 1'b1);
        sram_addr = 18'd1; sram_write_mask = 4'h0;
        tick();
        chk("alt_ready2", sram_ready, 1'b1);
        sram_addr = 18'd2; sram_data_in = 32'h5A5A0002; sram_write_mask = 4'hF;
        tick();
        chk("alt_ready3", sram_ready, 1'b1);
        chk("alt_oe0", ram_dq_oe, 1'b1);
        chk("alt_dq0", ram_dq_o, 32'hC0FFEE00);
        sram_addr = 18'd3; sram_write_mask = 4'h0;
        tick();
        sram_addr_valid = 1'b0;
        chk("alt_oe_rd", ram_dq_oe, 1'b0);
        tick();
        chk("alt_oe2", ram_dq_oe, 1'b1);
        chk("alt_dq2", ram_dq_o, 32'h5A5A0002);
        chk("alt_valid1", sram_data_out_valid, 1'b1);
        chk("alt_data1", sram_data_out, 32'h1111_0001);
        tick();
        chk("alt_gap", sram_data_out_valid, 1'b0);
        tick();
        chk("alt_valid3", sram_data_out_valid, 1'b1);
        chk("alt_data3", sram_data_out, 32'h3333_0003);
        chk("alt_mem0", mem[18'd0], 32'hC0FFEE00);
        chk("alt_mem2", mem[18'd2], 32'h5A5A0002);

        // Reset two cycles after a read of the top address flushes it
        tick();
        sram_addr = 18'h3FFFF; sram_write_mask = 4'h0; sram_addr_valid = 1'b1;
        tick();
        sram_addr_valid = 1'b0;
        chk("top_addr", ram_addr, 18'h3FFFF);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("flush_ce_n", ram_ce_n, 1'b1);
        chk("flush_we_n", ram_we_n, 1'b1);
        chk("flush_bw_n", ram_bw_n, 4'hF);
        chk("flush_addr", ram_addr, 18'h0);
        chk("flush_ready", sram_ready, 1'b0);
        chk("flush_data_out", sram_data_out, 32'h0);
        chk("flush_zz", ram_zz, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk("flush_valid", sram_data_out_valid, 1'b0);
            chk("flush_oe", ram_dq_oe, 1'b0);
            tick();
        end
        chk("reinit_ready", sram_ready, 1'b1);

        // Four idle RUN cycles, then a read of 0x00012
        repeat (4) tick();
        sram_addr = 18'h00012; sram_write_mask = 4'h0;
`ifdef SRAM_ZZ_EN
        chk("zz_sleep", ram_zz, 1'b1);
        chk("zz_ready", sram_ready, 1'b0);
        sram_addr_valid = 1'b1;
        tick();
        chk("zz_wake", ram_zz, 1'b0);
        chk("zz_wake_ready", sram_ready, 1'b0);
        tick(); tick();
        chk("zz_wake_ready2", sram_ready, 1'b0);
        tick();
        chk("zz_run_ready", sram_ready, 1'b1);
`else
        chk("idle_zz", ram_zz, 1'b0);
        chk("idle_ready", sram_ready, 1'b1);
        sram_addr_valid = 1'b1;
`endif
        tick();
        sram_addr_valid = 1'b0;
        repeat (3) tick();
        chk("late_valid", sram_data_out_valid, 1'b1);
        chk("late_data", sram_data_out, 32'hDEADBEEF);
        chk("dq_overlap", overlap, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
